hex_digit_scanner: RTL and testbench

//  Upstream feeder for the 4-bit-to-seven-segment decoder on the CPU board display path.

---
 rtl/hex_digit_scanner_pkg.sv | 18 +
 rtl/hex_digit_scanner_if.sv | 21 ++
 rtl/hex_digit_scanner_prescaler.sv | 27 ++
 rtl/hex_digit_scanner.sv | 103 ++++++++++
 tb/tb_hex_digit_scanner.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_digit_scanner_pkg.sv
// rtl/hex_digit_scanner_pkg.sv - shared constants, slot-state encoding and width helper for the hex digit scanner
package hex_scan_pkg;

    localparam int NIBBLE_W     = 4;
    localparam int DEF_PRESCALE = 50000;
    localparam int DEF_DEAD     = 2;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } slot_state_t;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_digit_scanner_if.sv
// rtl/hex_digit_scanner_if.sv - load/data bus and display outputs of the hex digit scanner
interface hex_digit_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [4*DIGITS-1:0]   held;
    logic [3:0]            nibble;
    logic [DIGITS-1:0]     digit_en_n;
    logic                  blank;

    modport master (
        output load, data,
        input  held, nibble, digit_en_n, blank
    );

    modport slave (
        input  load, data,
        output held, nibble, digit_en_n, blank
    );
endinterface

// File: rtl/hex_digit_scanner_prescaler.sv
// rtl/hex_digit_scanner_prescaler.sv - slot prescaler counting 0..PRESCALE-1 with end-of-slot tick
module scan_prescaler
    import hex_scan_pkg::*;
#(
    parameter  int PRESCALE = DEF_PRESCALE,
    localparam int PW       = cnt_w(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [PW-1:0] presc_next,
    output logic          tick
);

    logic [PW-1:0] presc;

    assign tick       = (presc == PW'(PRESCALE - 1));
    assign presc_next = tick ? '0 : presc + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else begin
            presc <= presc_next;
        end
    end

endmodule

// File: rtl/hex_digit_scanner.sv
// rtl/hex_digit_scanner.sv - latches a hex word and scans it one nibble per slot with dead-time and leading-zero blanking
module hex_digit_scanner
    import hex_scan_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int DEAD     = DEF_DEAD,
    parameter int BLANK_LZ = 1
) (
    input  logic               clk,
    input  logic               rst,
    hex_digit_scanner_if.slave bus
);

    localparam int DW = NIBBLE_W * DIGITS;
    localparam int PW = cnt_w(PRESCALE);
    localparam int IW = cnt_w(DIGITS);

    logic [PW-1:0]     presc_next;
    logic              tick;
    logic              in_guard;
    logic [DW-1:0]     held_q, held_next;
    logic [IW-1:0]     idx_q, idx_next;
    slot_state_t       state_q, state_next;
    logic [DIGITS-1:0] en_q, en_next;
    logic              blank_q, blank_next;
    logic              lz;

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .presc_next (presc_next),
        .tick       (tick)
    );

    // Digit k>0 goes dark when it and every nibble above it are zero.
    function automatic logic lz_blanked(input logic [DW-1:0] v, input logic [IW-1:0] k);
        logic any_nz;
        any_nz = 1'b0;
        if (BLANK_LZ == 0 || k == '0) begin
            return 1'b0;
        end
        for (int j = 1; j < DIGITS; j++) begin
            if (j >= int'(k) && v[j*NIBBLE_W +: NIBBLE_W] != '0) begin
                any_nz = 1'b1;
            end
        end
        return !any_nz;
    endfunction

    generate
        if (DEAD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (presc_next < PW'(DEAD));
        end
    endgenerate

    assign held_next = bus.load ? bus.data : held_q;
    assign idx_next  = !tick ? idx_q
                     : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    // Outputs are precomputed from next-cycle state so they land in step with presc/idx.
    always_comb begin
        state_next = state_q;
        en_next    = '1;
        blank_next = 1'b1;
        lz         = lz_blanked(held_next, idx_next);
        case (state_q)
            GUARD:   if (!in_guard) state_next = DRIVE;
            DRIVE:   if (in_guard)  state_next = GUARD;
            default: state_next = GUARD;
        endcase
        if (state_next == DRIVE && !lz) begin
            en_next    = ~(DIGITS'(1) << idx_next);
            blank_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q  <= '0;
            idx_q   <= '0;
            state_q <= GUARD;
            en_q    <= '1;
            blank_q <= 1'b1;
        end else begin
            held_q  <= held_next;
            idx_q   <= idx_next;
            state_q <= state_next;
            en_q    <= en_next;
            blank_q <= blank_next;
        end
    end

    assign bus.held       = held_q;
    assign bus.nibble     = held_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign bus.digit_en_n = en_q;
    assign bus.blank      = blank_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// tb/tb_hex_digit_scanner.sv - self-checking bench for hex_digit_scanner at PRESCALE=8, DEAD=2, DIGITS=4
module tb_hex_digit_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 1'b0;

    hex_digit_scanner_if #(.DIGITS(4)) bus ();

    hex_digit_scanner #(
        .DIGITS   (4),
        .PRESCALE (8),
        .DEAD     (2),
        .BLANK_LZ (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          slot;
        int          presc;
        logic [3:0]  nib;
        logic        blank;
        logic [3:0]  en;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    int          m_cnt;
    logic [2:0]  m_presc;
    logic [1:0]  m_idx;
    logic [15:0] m_held;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; m_presc <= '0; m_idx <= '0; m_held <= '0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (bus.load) m_held <= bus.data;
            if (m_presc == 3'd7) begin
                m_presc <= '0;
                m_idx   <= m_idx + 2'd1;
            end else begin
                m_presc <= m_presc + 3'd1;
            end
        end
    end

    function automatic logic mdl_blanked(input logic [1:0] k, input logic [15:0] h);
        return (k != 2'd0) && ((h >> (4 * k)) == 16'h0);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
            4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
            4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
            4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
            4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
            4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
            4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
            4'hE: return 7'b0000110; default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle reference: registered outputs as a function of the model's slot position.
    always @(negedge clk) begin
        if (chk_on) begin
            logic       bl;
            logic [3:0] e_en;
            bl   = (m_presc < 3'd2) || mdl_blanked(m_idx, m_held);
            e_en = bl ? 4'hF : ~(4'b0001 << m_idx);
            check("mdl_en", 32'(bus.digit_en_n), 32'(e_en));
            check("mdl_blank", 32'(bus.blank), 32'(bl));
            check("mdl_held", 32'(bus.held), 32'(m_held));
            check("mdl_nibble", 32'(bus.nibble), 32'(m_held[m_idx*4 +: 4]));
            check("mdl_onehot", 32'($countones(~bus.digit_en_n) <= 1), 32'd1);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.load = 1'b0;
        bus.data = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic load_once(input logic [15:0] d);
        bus.load = 1'b1;
        bus.data = d;
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    task automatic run_to(input int n);
        int guard_cnt;
        guard_cnt = 0;
        while (m_cnt < n && guard_cnt < 1000) begin
            @(posedge clk); #1;
            guard_cnt++;
        end
        check("run_to_reached", 32'(m_cnt), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{16'h1A2F, 0, 1, 4'hF, 1'b1, 4'hF});
        vecs.push_back('{16'h1A2F, 0, 2, 4'hF, 1'b0, 4'hE});
        vecs.push_back('{16'h1A2F, 0, 4, 4'hF, 1'b0, 4'hE});
        vecs.push_back('{16'h1A2F, 1, 1, 4'h2, 1'b1, 4'hF});
        vecs.push_back('{16'h1A2F, 1, 4, 4'h2, 1'b0, 4'hD});
        vecs.push_back('{16'h1A2F, 2, 4, 4'hA, 1'b0, 4'hB});
        vecs.push_back('{16'h1A2F, 3, 4, 4'h1, 1'b0, 4'h7});
        vecs.push_back('{16'h1A2F, 3, 7, 4'h1, 1'b0, 4'h7});
        vecs.push_back('{16'h0005, 0, 4, 4'h5, 1'b0, 4'hE});
        vecs.push_back('{16'h0005, 1, 4, 4'h0, 1'b1, 4'hF});
        vecs.push_back('{16'h0005, 2, 5, 4'h0, 1'b1, 4'hF});
        vecs.push_back('{16'h0005, 3, 6, 4'h0, 1'b1, 4'hF});
        vecs.push_back('{16'h0000, 0, 4, 4'h0, 1'b0, 4'hE});
        vecs.push_back('{16'h0500, 0, 4, 4'h0, 1'b0, 4'hE});
        vecs.push_back('{16'h0500, 1, 4, 4'h0, 1'b0, 4'hD});
        vecs.push_back('{16'h0500, 2, 4, 4'h5, 1'b0, 4'hB});
        vecs.push_back('{16'h0500, 3, 4, 4'h0, 1'b1, 4'hF});

        do_reset();
        check("reset_en", 32'(bus.digit_en_n), 32'hF);
        check("reset_blank", 32'(bus.blank), 32'd1);
        check("reset_held", 32'(bus.held), 32'h0);
        chk_on = 1'b1;

        foreach (vecs[i]) begin
            vec_t e;
            do_reset();
            exp_q.push_back(vecs[i]);
            load_once(vecs[i].data);
            run_to(8 * vecs[i].slot + vecs[i].presc);
            e = exp_q.pop_front();
            check($sformatf("vec%0d_en", i), 32'(bus.digit_en_n), 32'(e.en));
            check($sformatf("vec%0d_blank", i), 32'(bus.blank), 32'(e.blank));
            if (!e.blank) check($sformatf("vec%0d_nibble", i), 32'(bus.nibble), 32'(e.nib));
        end

        // Reload mid-slot: nibble follows next clock, slot edges stay put.
        do_reset();
        load_once(16'h1A2F);
        run_to(19);
        load_once(16'hBEEF);
        check("reload_nibble", 32'(bus.nibble), 32'hE);
        check("reload_en", 32'(bus.digit_en_n), 32'hB);
        run_to(23);
        check("reload_slot_end_en", 32'(bus.digit_en_n), 32'hB);
        run_to(24);
        check("reload_next_guard_en", 32'(bus.digit_en_n), 32'hF);
        run_to(28);
        check("reload_digit3_seg", 32'(seg7(bus.nibble)), 32'(7'b0000011));
        check("reload_digit3_en", 32'(bus.digit_en_n), 32'h7);

        // Asynchronous reset in the middle of a DRIVE slot.
        do_reset();
        load_once(16'h1A2F);
        run_to(12);
        #2 rst = 1'b1;
        #1;
        check("async_rst_en", 32'(bus.digit_en_n), 32'hF);
        check("async_rst_held", 32'(bus.held), 32'h0);
        check("async_rst_blank", 32'(bus.blank), 32'd1);
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_edge1_en", 32'(bus.digit_en_n), 32'hF);
        @(posedge clk); #1;
        check("post_rst_edge2_en", 32'(bus.digit_en_n), 32'hE);

        // Free run: two full scans, one wrap, twelve enabled clocks per digit.
        do_reset();
        load_once(16'h1A2F);
        begin
            int on_cnt[4];
            int last, wraps, multi;
            last = -1; wraps = 0; multi = 0;
            foreach (on_cnt[d]) on_cnt[d] = 0;
            for (int c = 0; c < 63; c++) begin
                if ($countones(~bus.digit_en_n) > 1) multi++;
                for (int d = 0; d < 4; d++) begin
                    if (!bus.digit_en_n[d]) begin
                        on_cnt[d]++;
                        if (last == 3 && d == 0) wraps++;
                        last = d;
                    end
                end
                @(posedge clk); #1;
            end
            check("free_run_cycles", 32'(m_cnt), 32'd64);
            for (int d = 0; d < 4; d++) check($sformatf("free_run_on_d%0d", d), 32'(on_cnt[d]), 32'd12);
            check("free_run_wraps", 32'(wraps), 32'd1);
            check("free_run_multi_low", 32'(multi), 32'd0);
        end

        // Load on the tick edge: the incoming digit uses the new word immediately.
        do_reset();
        load_once(16'h1A2F);
        run_to(7);
        load_once(16'h0003);
        check("tick_load_held", 32'(bus.held), 32'h0003);
        check("tick_load_nibble", 32'(bus.nibble), 32'h0);
        begin
            int stale;
            stale = 0;
            for (int p = 0; p < 7; p++) begin
                if (!bus.blank) stale++;
                @(posedge clk); #1;
            end
            if (!bus.blank) stale++;
            check("tick_load_no_stale", 32'(stale), 32'd0);
        end
        load_once(16'h0C30);
        check("tick_load2_nibble", 32'(bus.nibble), 32'hC);
        run_to(18);
        check("tick_load2_en", 32'(bus.digit_en_n), 32'hB);
        check("tick_load2_blank", 32'(bus.blank), 32'd0);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
